rank_seq: RTL and testbench

- Sequential ranker for combinations in the combinatorial number system; it is the inverse of the unrank datapath.
- Consumes a k-combination as a stream of elements c_k > c_(k-1) > ... > c_1, largest first.
- Produces rank = sum over i of C(c_i, i), using the same binomial table layout (row = element, col = position).
- Sits in front of the accelerator so software can round-trip rank/unrank.

---
 rtl/rank_pkg.sv | 16 +
 rtl/binom_rom.sv | 20 ++
 rtl/rank_seq.sv | 73 +++++++
 tb/tb_rank_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rank_pkg.sv
// rank_pkg: shared widths, ranker state encoding and binomial coefficient helper
package rank_pkg;
  localparam int NUM_W   = 11;
  localparam int ROWS    = 13;
  localparam int VALUE_W = 10;
  localparam int COL_W   = 4;
  localparam int ROW_W   = 4;
  typedef enum logic [1:0] {IDLE, ACCEPT, ADD, DONE} state_t;
  // Each partial product is itself a binomial, so the integer division is exact
  function automatic int binom(int n, int r);
    int res = 1;
    if (r < 0 || r > n) return 0;
    for (int i = 0; i < r; i++) res = res * (n - i) / (i + 1);
    return res;
  endfunction
endpackage

// File: rtl/binom_rom.sv
// binom_rom: registered C(row,col) lookup, zero for rows outside the table
module binom_rom import rank_pkg::*; #(
  parameter int ROWS_NUM    = ROWS,
  parameter int VALUE_WIDTH = VALUE_W,
  parameter int COL_WIDTH   = COL_W,
  parameter int ROW_WIDTH   = ROW_W
) (
  input  logic                   clk,
  input  logic [COL_WIDTH-1:0]   col,
  input  logic [ROW_WIDTH-1:0]   row,
  output logic [VALUE_WIDTH-1:0] data
);
  localparam int DEPTH = 2 ** (COL_WIDTH + ROW_WIDTH);
  localparam int NROW  = 2 ** ROW_WIDTH;
  logic [VALUE_WIDTH-1:0] tbl [DEPTH];
  for (genvar a = 0; a < DEPTH; a++) begin : g_tbl
    assign tbl[a] = VALUE_WIDTH'((a % NROW) < ROWS_NUM ? binom(a % NROW, a / NROW) : 0);
  end
  always_ff @(posedge clk) data <= tbl[{col, row}];
endmodule

// File: rtl/rank_seq.sv
// rank_seq: streams a descending k-combination and accumulates its combinatorial rank
module rank_seq import rank_pkg::*; #(
  parameter int NUM_WIDTH   = NUM_W,
  parameter int ROWS_NUM    = ROWS,
  parameter int VALUE_WIDTH = VALUE_W,
  parameter int COL_WIDTH   = COL_W,
  parameter int ROW_WIDTH   = ROW_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COL_WIDTH-1:0] k,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROW_WIDTH-1:0] in_elem,
  output logic                 rank_valid,
  input  logic                 rank_ready,
  output logic [NUM_WIDTH-1:0] rank,
  output logic                 err
);
  state_t state, next;
  logic [COL_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] prev;
  logic [NUM_WIDTH-1:0] acc;
  logic [VALUE_WIDTH-1:0] val;
  logic fire;
  binom_rom #(
    .ROWS_NUM(ROWS_NUM), .VALUE_WIDTH(VALUE_WIDTH),
    .COL_WIDTH(COL_WIDTH), .ROW_WIDTH(ROW_WIDTH)
  ) u_rom (
    .clk(clk), .col(col), .row(in_elem), .data(val)
  );
  assign in_ready   = state == ACCEPT;
  assign rank_valid = state == DONE;
  assign rank       = acc;
  assign fire       = in_valid && in_ready;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !start ? IDLE : (k == '0 ? DONE : ACCEPT);
      ACCEPT:  next = fire ? ADD : ACCEPT;
      ADD:     next = col == COL_WIDTH'(1) ? DONE : ACCEPT;
      DONE:    next = rank_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      acc   <= '0;
      prev  <= '1;
      err   <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        acc  <= '0;
        err  <= 1'b0;
        col  <= k;
        prev <= ROW_WIDTH'(ROWS_NUM);
      end
      // prev starts at ROWS_NUM so the first element only trips the range check
      if (fire) begin
        prev <= in_elem;
        if (in_elem >= ROW_WIDTH'(ROWS_NUM) || in_elem >= prev) err <= 1'b1;
      end
      if (state == ADD) begin
        acc <= acc + NUM_WIDTH'(val);
        col <= col - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rank_seq.sv
// tb_rank_seq: vector table plus random streams against a scoreboard of expected ranks
module tb_rank_seq;
  import rank_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, rank_ready = 0;
  logic [3:0] k = 0, in_elem = 0;
  logic in_ready, rank_valid, err;
  logic [10:0] rank;
  typedef struct {int k; int e[6]; int r; int er;} vec_t;
  typedef struct {int r; int er;} exp_t;
  exp_t sb[$];
  vec_t v[8];
  int checks = 0, errors = 0;
  int cur_k;
  int cur_e[6];
  always #5 clk = ~clk;
  rank_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k),
    .in_valid(in_valid), .in_ready(in_ready), .in_elem(in_elem),
    .rank_valid(rank_valid), .rank_ready(rank_ready), .rank(rank), .err(err)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  function automatic exp_t model();
    exp_t x;
    int p = ROWS;
    x.r = 0;
    x.er = 0;
    for (int i = 0; i < cur_k; i++) begin
      if (cur_e[i] < ROWS) x.r += binom(cur_e[i], cur_k - i);
      if (cur_e[i] >= ROWS || cur_e[i] >= p) x.er = 1;
      p = cur_e[i];
    end
    return x;
  endfunction
  task automatic run(input int gap_max, input int hold, input bit pulse, input exp_t e);
    exp_t x;
    int t;
    @(negedge clk);
    start = 1;
    k = 4'(cur_k);
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    k = 0;
    if (cur_k == 0) chk("k0_latency", int'(rank_valid), 1);
    for (int i = 0; i < cur_k; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk);
        if (pulse) begin
          start = 1;
          k = 4'd5;
        end
      end
      start = 0;
      k = 0;
      in_valid = 1;
      in_elem = 4'(cur_e[i]);
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("accept_ready", int'(in_ready), 1);
      @(negedge clk);
      in_valid = 0;
    end
    if (cur_k != 0) begin
      chk("pre_valid", int'(rank_valid), 0);
      @(negedge clk);
      chk("valid_latency", int'(rank_valid), 1);
    end
    chk("no_extra_accept", int'(in_ready), 0);
    chk("sb_depth", sb.size(), 1);
    x = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 0) begin
        start = 1;
        k = 4'd1;
      end
      chk("hold_valid", int'(rank_valid), 1);
      chk("hold_rank", int'(rank), x.r);
      chk("hold_err", int'(err), x.er);
      @(negedge clk);
      start = 0;
      k = 0;
    end
    chk("rank", int'(rank), x.r);
    chk("err", int'(err), x.er);
    rank_ready = 1;
    @(negedge clk);
    rank_ready = 0;
    chk("drop_valid", int'(rank_valid), 0);
    chk("idle_ready", int'(in_ready), 0);
    chk("rank_kept", int'(rank), x.r);
  endtask
  initial begin
    exp_t e;
    int pos;
    v[0] = '{3, '{4, 2, 1, 0, 0, 0}, 6, 0};
    v[1] = '{3, '{12, 11, 10, 0, 0, 0}, 285, 0};
    v[2] = '{6, '{12, 11, 10, 9, 8, 7}, 1715, 0};
    v[3] = '{0, '{0, 0, 0, 0, 0, 0}, 0, 0};
    v[4] = '{1, '{0, 0, 0, 0, 0, 0}, 0, 0};
    v[5] = '{1, '{12, 0, 0, 0, 0, 0}, 12, 0};
    v[6] = '{3, '{5, 5, 1, 0, 0, 0}, 21, 1};
    v[7] = '{2, '{13, 0, 0, 0, 0, 0}, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_rank_valid", int'(rank_valid), 0);
    chk("rst_rank", int'(rank), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      cur_k = v[i].k;
      cur_e = v[i].e;
      e.r = v[i].r;
      e.er = v[i].er;
      run(i == 0 ? 0 : 3, (i % 3 == 0) ? 5 : 1, i >= 5, e);
    end
    for (int n = 0; n < 6; n++) begin
      cur_k = $urandom_range(6, 1);
      pos = 12;
      for (int i = 0; i < 6; i++) cur_e[i] = 0;
      for (int i = 0; i < cur_k; i++) begin
        cur_e[i] = $urandom_range(pos, cur_k - 1 - i);
        pos = cur_e[i] - 1;
      end
      run(4, 5, n[0], model());
    end
    // abort in the ADD cycle of element 2 of 3, with err already set
    @(negedge clk);
    start = 1;
    k = 4'd3;
    @(negedge clk);
    start = 0;
    k = 0;
    in_valid = 1;
    in_elem = 4'd4;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    in_valid = 1;
    in_elem = 4'd4;
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_valid", int'(rank_valid), 0);
    chk("mid_rst_rank", int'(rank), 0);
    chk("mid_rst_err", int'(err), 0);
    @(negedge clk);
    chk("post_rst_idle", int'(in_ready), 0);
    cur_k = 2;
    cur_e = '{3, 0, 0, 0, 0, 0};
    e.r = 3;
    e.er = 0;
    run(1, 2, 0, e);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
